// File: rtl/player_motion_controller.sv
// player_motion_controller: probes the collision detector each frame, then commits a 1-px step, an enemy knockback or nothing
module player_motion_controller #(
    parameter int X_INIT        = 152,
    parameter int Y_INIT        = 112,
    parameter int X_MAX         = 303,
    parameter int Y_MAX         = 223,
    parameter int KNOCKBACK_PX  = 8,
    parameter int INVULN_FRAMES = 60,
    parameter int ATTACK_FRAMES = 12,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       c_map_collision,
    input  logic       c_e1_collision,
    output logic       collision_enable,
    output logic [8:0] char_x,
    output logic [7:0] char_y,
    output logic [2:0] direction_char,
    output logic [2:0] facing_char,
    output logic       hit,
    output logic       invulnerable,
    output logic       busy
);
    localparam logic [2:0] NO_ACTION = 3'd0, ATTACK = 3'd1, UP = 3'd2, DOWN = 3'd3, LEFT = 3'd4, RIGHT = 3'd5;
    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam int AW = $clog2(ATTACK_FRAMES + 1);
    localparam int WW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DECIDE, CHECK, SAMPLE} state_t;

    state_t        state_q;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [2:0]    dir_q, face_q, pick;
    logic          en_q, hit_q, enemy_hit;
    logic [IW-1:0] inv_q;
    logic [AW-1:0] atk_q;
    logic [WW-1:0] wait_q;
    logic [9:0]    kx_sub, kx_add;
    logic [8:0]    ky_sub, ky_add;

    assign collision_enable = en_q;
    assign char_x           = x_q;
    assign char_y           = y_q;
    assign direction_char   = dir_q;
    assign facing_char      = face_q;
    assign hit              = hit_q;
    assign invulnerable     = inv_q != '0;
    assign busy             = state_q != IDLE;

    assign kx_sub    = {1'b0, x_q} - 10'(KNOCKBACK_PX);
    assign kx_add    = {1'b0, x_q} + 10'(KNOCKBACK_PX);
    assign ky_sub    = {1'b0, y_q} - 9'(KNOCKBACK_PX);
    assign ky_add    = {1'b0, y_q} + 9'(KNOCKBACK_PX);
    assign enemy_hit = c_e1_collision && inv_q == '0;
    assign pick      = btn_attack ? ATTACK : btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : btn_right ? RIGHT : NO_ACTION;

    // Position the SAMPLE cycle would commit: clamped knockback, else a bounded 1-px step, else hold
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (enemy_hit) begin
            x_d = face_q == RIGHT ? (kx_sub[9] ? 9'd0 : kx_sub[8:0]) :
                  face_q == LEFT  ? (kx_add > 10'(X_MAX) ? 9'(X_MAX) : kx_add[8:0]) : x_q;
            y_d = face_q == DOWN  ? (ky_sub[8] ? 8'd0 : ky_sub[7:0]) :
                  face_q == UP    ? (ky_add > 9'(Y_MAX) ? 8'(Y_MAX) : ky_add[7:0]) : y_q;
        end else if (!c_map_collision) begin
            x_d = dir_q == LEFT && x_q != 9'd0 ? x_q - 9'd1 : dir_q == RIGHT && x_q < 9'(X_MAX) ? x_q + 9'd1 : x_q;
            y_d = dir_q == UP && y_q != 8'd0 ? y_q - 8'd1 : dir_q == DOWN && y_q < 8'(Y_MAX) ? y_q + 8'd1 : y_q;
        end
    end

    // Frame sequencer: IDLE -> DECIDE -> CHECK (settle) -> SAMPLE, plus the free-running immunity countdown
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 9'(X_INIT);
            y_q     <= 8'(Y_INIT);
            dir_q   <= NO_ACTION;
            face_q  <= DOWN;
            en_q    <= 1'b0;
            hit_q   <= 1'b0;
            inv_q   <= '0;
            atk_q   <= '0;
            wait_q  <= '0;
        end else begin
            hit_q <= 1'b0;
            if (frame_tick && inv_q != '0)
                inv_q <= inv_q - IW'(1);
            case (state_q)
                IDLE: if (frame_tick) begin
                    if (atk_q != '0) begin
                        atk_q <= atk_q - AW'(1);
                        dir_q <= ATTACK;
                    end else
                        state_q <= DECIDE;
                end
                DECIDE: begin
                    state_q <= CHECK;
                    en_q    <= 1'b1;
                    wait_q  <= '0;
                    dir_q   <= pick;
                    if (pick >= UP)
                        face_q <= pick;
                    if (btn_attack)
                        atk_q <= AW'(ATTACK_FRAMES - 1);
                end
                CHECK: if (wait_q == WW'(SETTLE_CYCLES - 1))
                    state_q <= SAMPLE;
                else
                    wait_q <= wait_q + WW'(1);
                SAMPLE: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                    if (enemy_hit) begin
                        hit_q <= 1'b1;
                        inv_q <= IW'(INVULN_FRAMES);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_player_motion_controller.sv
// tb_player_motion_controller: vector table, hand-written corner sequences and a randomized run against a frame-level model
module tb_player_motion_controller;
    localparam int XI = 152, YI = 112, XM = 303, YM = 223, KB = 8, INV = 60, ATK = 12;

    logic       clock = 0, reset = 0, frame_tick = 0;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_attack = 0;
    logic       c_map_collision = 0, c_e1_collision = 0;
    logic       collision_enable, hit, invulnerable, busy;
    logic [8:0] char_x;
    logic [7:0] char_y;
    logic [2:0] direction_char, facing_char;

    player_motion_controller dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .c_map_collision(c_map_collision), .c_e1_collision(c_e1_collision),
        .collision_enable(collision_enable), .char_x(char_x), .char_y(char_y),
        .direction_char(direction_char), .facing_char(facing_char),
        .hit(hit), .invulnerable(invulnerable), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Frame-level model: whole-frame effect of one accepted tick, straight from the movement rules
    int mx, my, mface, mdir, minv, matk, mhit, mhold;

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic void model_reset();
        mx = XI; my = YI; mface = 3; mdir = 0; minv = 0; matk = 0; mhit = 0; mhold = 0;
    endfunction

    function automatic void model_frame(input bit up, dn, lf, rt, at, map, e1, extra);
        mhit = 0;
        mhold = 0;
        minv = clampi(minv - 1, 0, INV);
        if (matk > 0) begin
            matk--;
            mdir = 1;
            mhold = 1;
            return;
        end
        if (extra) minv = clampi(minv - 1, 0, INV);
        mdir = at ? 1 : up ? 2 : dn ? 3 : lf ? 4 : rt ? 5 : 0;
        if (at) matk = ATK - 1;
        if (mdir >= 2) mface = mdir;
        if (e1 && minv == 0) begin
            mhit = 1;
            minv = INV;
            if (mface == 2) my = clampi(my + KB, 0, YM);
            if (mface == 3) my = clampi(my - KB, 0, YM);
            if (mface == 4) mx = clampi(mx + KB, 0, XM);
            if (mface == 5) mx = clampi(mx - KB, 0, XM);
        end else if (!map) begin
            if (mdir == 2) my = clampi(my - 1, 0, YM);
            if (mdir == 3) my = clampi(my + 1, 0, YM);
            if (mdir == 4) mx = clampi(mx - 1, 0, XM);
            if (mdir == 5) mx = clampi(mx + 1, 0, XM);
        end
    endfunction

    int ob_x, ob_y, ob_dir, ob_face, ob_hit, ob_inv, ob_busy, ob_en, ob_hit2;

    task automatic do_reset();
        @(negedge clock);
        {btn_up, btn_down, btn_left, btn_right, btn_attack, c_map_collision, c_e1_collision, frame_tick} = '0;
        reset = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        model_reset();
    endtask

    // One tick, an optional extra tick while busy, then observe five clocks later and once more for the pulse end
    task automatic run_frame(input bit up, dn, lf, rt, at, map, e1, extra);
        logic [4:0] ens;
        @(negedge clock);
        {btn_up, btn_down, btn_left, btn_right, btn_attack} = {up, dn, lf, rt, at};
        {c_map_collision, c_e1_collision} = {map, e1};
        frame_tick = 1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clock);
            frame_tick = extra && n == 2;
            ens[n-1] = collision_enable;
        end
        ob_x = char_x; ob_y = char_y; ob_dir = direction_char; ob_face = facing_char;
        ob_hit = hit; ob_inv = invulnerable; ob_busy = busy; ob_en = ens;
        @(negedge clock);
        ob_hit2 = hit;
    endtask

    task automatic mframe(input bit up, dn, lf, rt, at, map, e1, extra);
        model_frame(up, dn, lf, rt, at, map, e1, extra);
        run_frame(up, dn, lf, rt, at, map, e1, extra);
        chk("x", ob_x, mx);
        chk("y", ob_y, my);
        chk("direction", ob_dir, mdir);
        chk("facing", ob_face, mface);
        chk("hit", ob_hit, mhit);
        chk("hit_pulse_end", ob_hit2, 0);
        chk("invulnerable", ob_inv, minv != 0);
        chk("busy_after", ob_busy, 0);
        chk("enable_window", ob_en, mhold ? 0 : 5'b01110);
    endtask

    typedef struct {
        bit up, dn, lf, rt, at, map, e1;
        int x, y, dir, face, hit;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int cnt, cnt2;
        tbl = '{
            '{0,0,0,1,0, 0,0, 153,112,5,5,0},
            '{1,0,0,0,0, 1,0, 153,112,2,2,0},
            '{1,0,0,0,0, 0,0, 153,111,2,2,0},
            '{0,0,1,1,0, 0,0, 152,111,4,4,0},
            '{0,1,1,0,0, 0,0, 152,112,3,3,0},
            '{0,0,0,0,0, 0,0, 152,112,0,3,0},
            '{0,0,0,1,0, 0,1, 144,112,5,5,1},
            '{0,0,0,1,0, 0,1, 145,112,5,5,0},
            '{0,1,0,0,0, 1,1, 145,112,3,3,0},
            '{1,0,0,0,0, 0,0, 145,111,2,2,0}
        };

        do_reset();
        @(negedge clock);
        chk("rst_x", char_x, XI);
        chk("rst_y", char_y, YI);
        chk("rst_facing", facing_char, 3);
        chk("rst_direction", direction_char, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enable", collision_enable, 0);
        chk("rst_hit", hit, 0);
        chk("rst_invulnerable", invulnerable, 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].up, tbl[i].dn, tbl[i].lf, tbl[i].rt, tbl[i].at, tbl[i].map, tbl[i].e1, 0);
            chk($sformatf("tbl%0d_x", i), ob_x, tbl[i].x);
            chk($sformatf("tbl%0d_y", i), ob_y, tbl[i].y);
            chk($sformatf("tbl%0d_dir", i), ob_dir, tbl[i].dir);
            chk($sformatf("tbl%0d_face", i), ob_face, tbl[i].face);
            chk($sformatf("tbl%0d_hit", i), ob_hit, tbl[i].hit);
            chk($sformatf("tbl%0d_en", i), ob_en, 5'b01110);
        end

        // reset in the middle of a step leaves nothing committed
        do_reset();
        @(negedge clock);
        btn_right = 1;
        frame_tick = 1;
        @(negedge clock);
        frame_tick = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        repeat (6) @(negedge clock);
        chk("midrst_x", char_x, XI);
        chk("midrst_busy", busy, 0);
        chk("midrst_enable", collision_enable, 0);
        btn_right = 0;

        // edge clamps on x
        do_reset();
        repeat (XI) mframe(0,0,1,0,0, 0,0, 0);
        chk("left_edge", char_x, 0);
        mframe(0,0,1,0,0, 0,0, 0);
        chk("left_clamp", char_x, 0);
        repeat (XM) mframe(0,0,0,1,0, 0,0, 0);
        chk("right_edge", char_x, XM);
        mframe(0,0,0,1,0, 0,0, 0);
        chk("right_clamp", char_x, XM);

        // knockback to 0 and the invulnerability window
        do_reset();
        repeat (XI - 5) mframe(0,0,1,0,0, 0,0, 0);
        mframe(0,0,0,1,0, 1,0, 0);
        chk("pre_hit_x", char_x, 5);
        chk("pre_hit_facing", facing_char, 5);
        mframe(0,0,0,1,0, 0,1, 0);
        chk("kb_hit", ob_hit, 1);
        chk("kb_x_clamped", ob_x, 0);
        chk("kb_invulnerable", ob_inv, 1);
        cnt = 0;
        repeat (INV - 1) begin
            mframe(0,0,0,0,0, 0,1, 0);
            cnt += ob_hit;
        end
        chk("hits_while_immune", cnt, 0);
        mframe(0,0,0,0,0, 0,1, 0);
        chk("hit_after_window", ob_hit, 1);

        // attack overrides down for twelve frames
        do_reset();
        cnt = 0;
        cnt2 = 0;
        repeat (ATK) begin
            mframe(0,1,0,0,1, 0,0, 0);
            cnt += ob_dir == 1;
            cnt2 += ob_y != YI;
        end
        chk("attack_frames", cnt, ATK);
        chk("attack_y_moves", cnt2, 0);
        mframe(0,1,0,0,0, 0,0, 0);
        chk("after_attack_dir", ob_dir, 3);
        chk("after_attack_y", ob_y, YI + 1);

        // a tick while busy is dropped, not queued
        do_reset();
        mframe(0,0,0,1,0, 0,0, 1);
        chk("drop_x", ob_x, XI + 1);
        repeat (8) @(negedge clock);
        chk("drop_busy", busy, 0);
        chk("drop_x_later", char_x, XI + 1);

        // randomized frames against the model
        do_reset();
        repeat (300) begin
            bit up, dn, lf, rt, at, map, e1, ex;
            up = $urandom_range(9) < 3;
            dn = $urandom_range(9) < 3;
            lf = $urandom_range(9) < 3;
            rt = $urandom_range(9) < 3;
            at = $urandom_range(19) == 0;
            map = $urandom_range(9) < 3;
            e1 = $urandom_range(9) < 2;
            ex = matk == 0 && $urandom_range(7) == 0;
            mframe(up, dn, lf, rt, at, map, e1, ex);
            repeat ($urandom_range(2)) @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
